// File: rtl/wave_sequencer.sv
// Playlist controller driving the waveform generator select and reset.
// Optional SEQ_IRQ_EN adds a sticky completion/abort interrupt (irq, irq_clr).
module wave_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
`ifdef SEQ_IRQ_EN
    input  logic               irq_clr,
    output logic               irq,
`endif
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [2:0]         wr_sel,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [AW:0]        seq_len,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    output logic [2:0]         select,
    output logic               gen_rst,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      entry_idx,
    output logic               period_tick
);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        PLAY,
        FINISH
    } state_t;

    localparam logic [AW:0]        DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0]        LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0]      IDX_ONE = AW'(1);
    localparam logic [DWELL_W-1:0] DW_ONE  = DWELL_W'(1);

    state_t state, state_n;

    logic [2:0]         tsel   [DEPTH];
    logic [DWELL_W-1:0] tdwell [DEPTH];

    logic [AW-1:0]      idx, idx_n;
    logic [7:0]         scnt, scnt_n;
    logic [DWELL_W-1:0] pcnt, pcnt_n;
    logic [AW:0]        len, len_n;
    logic               lp, lp_n;
    logic               last;
    logic               entry_end;
    logic               run_n;

    assign entry_idx = idx;
    assign last      = ({1'b0, idx} + LEN_ONE) >= len;
    // dwell of 0 wraps to the full 2^DWELL_W periods via modular compare
    assign entry_end = (scnt == 8'hff) && (pcnt == tdwell[idx] - DW_ONE);
    assign run_n     = (state_n == PRIME) || (state_n == PLAY);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        scnt_n  = scnt;
        pcnt_n  = pcnt;
        len_n   = len;
        lp_n    = lp;
        unique case (state)
            IDLE: begin
                if (start && !stop && seq_len != '0) begin
                    state_n = PRIME;
                    idx_n   = '0;
                    scnt_n  = '0;
                    pcnt_n  = '0;
                    len_n   = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
                    lp_n    = loop;
                end
            end
            PRIME: begin
                scnt_n = '0;
                pcnt_n = '0;
                if (stop) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    scnt_n  = '0;
                    pcnt_n  = '0;
                end else if (entry_end) begin
                    scnt_n = '0;
                    pcnt_n = '0;
                    if (!last) begin
                        state_n = PRIME;
                        idx_n   = idx + IDX_ONE;
                    end else if (lp) begin
                        state_n = PRIME;
                        idx_n   = '0;
                    end else begin
                        state_n = FINISH;
                    end
                end else begin
                    scnt_n = scnt + 8'd1;
                    if (scnt == 8'hff) begin
                        pcnt_n = pcnt + DW_ONE;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
                idx_n   = '0;
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            scnt  <= '0;
            pcnt  <= '0;
            len   <= '0;
            lp    <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            scnt  <= scnt_n;
            pcnt  <= pcnt_n;
            len   <= len_n;
            lp    <= lp_n;
        end
    end

    // Outputs are registered from next-state values so they line up with state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            select      <= '0;
            gen_rst     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            select      <= run_n ? tsel[idx_n] : 3'd0;
            gen_rst     <= (state_n != PLAY);
            busy        <= run_n;
            done        <= (state_n == FINISH);
            period_tick <= (state_n == PLAY) && (scnt_n == 8'hff);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tsel[i]   <= '0;
                tdwell[i] <= '0;
            end
        end else if (wr_en && state == IDLE) begin
            tsel[wr_addr]   <= wr_sel;
            tdwell[wr_addr] <= wr_dwell;
        end
    end

`ifdef SEQ_IRQ_EN
    logic abort;
    logic irq_set;

    assign abort   = stop && ((state == PRIME) || (state == PLAY));
    // Holding set through the FINISH cycle lets set win over a clear there
    assign irq_set = abort || (state_n == FINISH) || (state == FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (irq_set) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
Playlist controller that drives the waveform generator processor's select input and reset. It holds a small table of {waveform select, dwell} entries and plays them in order. Each entry lasts a programmed number of 256-sample waveform periods, with an optional loop back to entry 0. It sits between the host/config logic and the generator, and the generator's rst is driven from gen_rst.

Parameters:
DEPTH, 4, number of playlist entries (power of 2, >=2); AW = log2(DEPTH)
DWELL_W, 8, width of per-entry dwell field, in waveform periods

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  table write strobe (honoured only in IDLE)
wr_addr  in  AW  table entry index
wr_sel  in  3  waveform select for entry (0..5 meaningful; stored verbatim)
wr_dwell  in  DWELL_W  dwell in periods; 0 means 2^DWELL_W
seq_len  in  AW+1  number of entries to play, sampled on start
loop  in  1  repeat playlist, sampled on start
start  in  1  begin playback (level sampled each clk)
stop  in  1  abort playback
select  out  3  to generator select
gen_rst  out  1  to generator rst; high holds generator output at 0
busy  out  1  high in PRIME/PLAY
done  out  1  one-cycle pulse on normal completion
entry_idx  out  AW  entry currently playing
period_tick  out  1  one-cycle pulse on last sample of each period in PLAY

Behaviour:
- Async rst: state=IDLE; all table entries={sel 0, dwell 0}; select=0, gen_rst=1, busy=0, done=0, entry_idx=0, period_tick=0; internal counters=0.
- Table writes occur on a clk edge when wr_en=1 and state=IDLE. Writes in any other state are dropped.
- States: IDLE, PRIME, PLAY, FINISH.
- IDLE: gen_rst=1, select=0, busy=0.
  - start=1, stop=0, seq_len!=0 -> PRIME with idx=0. seq_len and loop are latched; seq_len>DEPTH clamps to DEPTH.
  - start with seq_len=0 is ignored.
  - start and stop together -> stay IDLE.
- PRIME (exactly 1 cycle): gen_rst=1, select=table[idx].sel, entry_idx=idx, sample_cnt=0, period_cnt=0. Next state is PLAY.
- PLAY: gen_rst=0, select held.
  - sample_cnt (8 bit) increments each clk.
  - period_tick=1 when sample_cnt==255.
  - period_cnt (DWELL_W bit) increments on each sample_cnt wrap.
- Entry end: sample_cnt==255 and period_cnt==dwell-1, computed mod 2^DWELL_W, so dwell 0 gives 2^DWELL_W periods.
  - If idx < len-1: idx+1, go to PRIME.
  - Else if loop: idx=0, go to PRIME.
  - Else: go to FINISH.
- FINISH (1 cycle): done=1, gen_rst=1, select=0, busy=0. Next state is IDLE.
- Entry duration is 1 PRIME cycle + dwell*256 PLAY cycles.
- stop=1 in PRIME or PLAY -> IDLE on the next edge. No done pulse; counters cleared; idx=0.
- stop has priority over entry-end in the same cycle.
- start while busy is ignored.
- Table contents persist across playbacks.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro SEQ_IRQ_EN.
- Defined: adds ports irq (out, 1) and irq_clr (in, 1).
  - irq is a sticky flag set on the FINISH cycle and also on a stop abort.
  - irq clears on irq_clr=1; set wins if both occur in the same cycle.
  - irq resets to 0.
- Undefined: neither port exists, and there is no irq logic.

Test Plan:
1. Reset, write entry0={sel1, dwell2} and entry1={sel3, dwell1}, seq_len=2, loop=0, start pulse on cycle 0.
   -> PRIME on cycle 1 (gen_rst=1, select=1).
   -> PLAY cycles 2..513 with select=1 and period_tick on cycles 257 and 513.
   -> PRIME on cycle 514 (select=3), PLAY cycles 515..770.
   -> done=1 on cycle 771 only; busy=0 and gen_rst=1 from cycle 771.
2. Same table with loop=1.
   -> After entry1, entry_idx returns to 0, select=1, and PRIME recurs on cycle 771.
   -> stop asserted on cycle 900 -> IDLE on cycle 901, gen_rst=1, no done pulse.
3. entry0={sel2, dwell0}, seq_len=1 -> PLAY lasts exactly 65536 cycles, then done.
4. wr_en during PLAY writing entry0 sel=5 -> after done, replay still shows the original select.
   Start with seq_len=0 -> busy stays 0.
   start and stop together -> stays IDLE.
5. Async rst mid-PLAY, asserted between clk edges -> select=0, gen_rst=1, busy=0 immediately.
   Subsequent playback shows select=0 for all entries, since the table was cleared.
6. With SEQ_IRQ_EN: irq rises with done and stays high until irq_clr.
   irq_clr in the same cycle as a completion leaves irq=1.
